// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package adder_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_RUN  = 2'd1;
  localparam logic [1:0] ENC_HOLD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ENC_IDLE,
    RUN  = ENC_RUN,
    HOLD = ENC_HOLD
  } state_t;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell used for the per-bit serial add.
module fullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first add through one full-adder cell, valid/ready on both sides.
// Optional two's-complement overflow output when SERIAL_ADDER_OVF_EN is defined.
//
// state | meaning
// IDLE  | ready for operands, no result presented
// RUN   | one bit added per cycle, bit counter 0..WIDTH-1
// HOLD  | result presented until the consumer takes it
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_shift;
  logic               w_last;
  logic               w_s;
  logic               w_co;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [CNT_W-1:0]   r_cnt;
`ifdef SERIAL_ADDER_OVF_EN
  logic               r_ovf;
`endif

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    w_shift   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        w_shift = 1'b1;
        if (w_last) begin
          w_next = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  fullAdder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_co)
  );

  // Sum bits enter at the MSB end so after WIDTH shifts bit 0 sits at sum[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_sum   <= '0;
      r_carry <= cin;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_shift) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_carry <= w_co;
      if (w_last) begin
        r_cout <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
        // r_carry here is the carry into the MSB.
        r_ovf  <= r_carry ^ w_co;
`endif
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corner cases plus random ops vs. an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; jam keeps in_valid high with fresh junk operands during RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input int hold, input bit jam);
    logic [W:0]   ref_full;
    logic [W-1:0] ref_sum;
    logic         ref_cout;
    logic         ref_ovf;
    int           lat;
    ref_full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    ref_sum  = ref_full[W-1:0];
    ref_cout = ref_full[W];
    ref_ovf  = (ta[W-1] == tb[W-1]) && (ref_sum[W-1] != ta[W-1]);

    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    tick();
    if (!jam) in_valid = 1'b0;
    chk("in_ready_run", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      if (jam) begin
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    // WIDTH edges after the accept edge: accept cycle plus WIDTH bit cycles.
    chk("latency", lat, W);
    chk("sum", {24'd0, sum}, {24'd0, ref_sum});
    chk("cout", {31'd0, cout}, {31'd0, ref_cout});
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, ref_ovf});
`else
    if (ref_ovf === 1'bx) chk("ovf_model", 32'd0, 32'd1);
`endif
    for (int i = 0; i < hold; i++) begin
      if (jam) begin
        in_valid = 1'b1;
        a = W'($urandom);
      end
      tick();
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_sum", {24'd0, sum}, {24'd0, ref_sum});
      chk("hold_cout", {31'd0, cout}, {31'd0, ref_cout});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("no_accept_after_rst", {31'd0, in_ready}, 32'd1);

    run_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1, 5, 1'b0);

    // Reset in the middle of RUN, with four bits already processed.
    a = 8'h3C; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_sum", {24'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 2 * W; i++) begin
      tick();
      if (out_valid) seen_valid++;
    end
    chk("midrst_no_result", seen_valid, 0);
    run_op(8'h01, 8'h02, 1'b0, 0, 1'b0);

    run_op(8'h12, 8'h34, 1'b0, 2, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
